dram_cmd_issuer: RTL and testbench

Stage directly downstream of the timing controller. Each cycle it takes the per-burst command vector, selects the single issued command and drives it onto the DRAM command/address bus, registered. For read and write commands it runs the fixed-latency data phase: it streams write beats out of the owning burst slot, captures read beats, and pulses a per-burst done flag back to the burst buffers.

---
 rtl/dram_cmd_issuer_pkg.sv | 42 ++++
 rtl/dram_cmd_issuer_if.sv | 38 +++
 rtl/dram_cmd_issuer_burst_beat_sequencer.sv | 155 +++++++++++++++
 rtl/dram_cmd_issuer.sv | 113 +++++++++++
 tb/tb_dram_cmd_issuer.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/dram_cmd_issuer_pkg.sv
// Shared DRAM command/address types plus the data-phase direction and FSM encodings
// used by the command issuer and its beat sequencer.
package types_def;

  localparam int banks_no       = 4;
  localparam int bank_groups_no = 4;
  localparam int row_addres_len = 16;
  localparam int col_addres_len = 10;

  typedef enum logic [2:0] {
    none      = 3'd0,
    activate  = 3'd1,
    precharge = 3'd2,
    read_cmd  = 3'd3,
    write_cmd = 3'd4,
    refresh   = 3'd5
  } command;

  typedef struct packed {
    logic [row_addres_len-1:0]          row;
    logic [col_addres_len-1:0]          column;
    logic [$clog2(banks_no)-1:0]        bank;
    logic [$clog2(bank_groups_no)-1:0]  bank_group;
  } address_type;

  typedef enum logic {
    DIR_RD = 1'b0,
    DIR_WR = 1'b1
  } data_dir_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    XFER_WR = 2'd2,
    XFER_RD = 2'd3
  } data_fsm_t;

  function automatic logic is_data_cmd(input command c);
    return (c == read_cmd) || (c == write_cmd);
  endfunction

endpackage

// File: rtl/dram_cmd_issuer_if.sv
// Burst-buffer side and DRAM-bus side signals of the command issuer.
// master = surrounding system (timing controller, burst buffers, DRAM); slave = issuer.
interface dram_cmd_issuer_if #(
  parameter int NO_OF_BURSTS = 4,
  parameter int DATA_W       = 16
);
  import types_def::*;

  localparam int ID_W = $clog2(NO_OF_BURSTS);

  command      [NO_OF_BURSTS-1:0] burst_cmd_i;
  address_type [NO_OF_BURSTS-1:0] burst_addr_i;
  logic        [NO_OF_BURSTS-1:0] wr_data_req_o;
  logic        [DATA_W-1:0]       wr_data_i;
  logic        [DATA_W-1:0]       rd_data_o;
  logic                           rd_valid_o;
  logic        [ID_W-1:0]         rd_id_o;
  logic        [NO_OF_BURSTS-1:0] burst_done_o;
  command                         dram_cmd_o;
  address_type                    dram_addr_o;
  logic        [DATA_W-1:0]       dram_dq_o;
  logic                           dram_dq_oe_o;
  logic        [DATA_W-1:0]       dram_dq_i;
  logic        [1:0]              err_o;

  modport master (
    output burst_cmd_i, burst_addr_i, wr_data_i, dram_dq_i,
    input  wr_data_req_o, rd_data_o, rd_valid_o, rd_id_o, burst_done_o,
           dram_cmd_o, dram_addr_o, dram_dq_o, dram_dq_oe_o, err_o
  );

  modport slave (
    input  burst_cmd_i, burst_addr_i, wr_data_i, dram_dq_i,
    output wr_data_req_o, rd_data_o, rd_valid_o, rd_id_o, burst_done_o,
           dram_cmd_o, dram_addr_o, dram_dq_o, dram_dq_oe_o, err_o
  );

endinterface

// File: rtl/dram_cmd_issuer_burst_beat_sequencer.sv
// Fixed-latency data phase for one RD/WR at a time: delay count, beat count,
// write-beat requests, DQ drive, read capture and per-slot done pulse.
//
// state   | meaning
// IDLE    | no data phase in flight, a start is accepted
// WAIT    | counting down the read/write latency
// XFER_WR | streaming write beats onto DQ
// XFER_RD | sampling read beats from DQ
module burst_beat_sequencer
  import types_def::*;
#(
  parameter int NO_OF_BURSTS = 4,
  parameter int BURST_LEN    = 8,
  parameter int RD_LAT       = 6,
  parameter int WR_LAT       = 4,
  parameter int DATA_W       = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start_i,
  input  data_dir_t                       dir_i,
  input  logic [$clog2(NO_OF_BURSTS)-1:0] id_i,
  input  logic [DATA_W-1:0]               wr_data_i,
  input  logic [DATA_W-1:0]               dram_dq_i,
  output logic                            busy_o,
  output logic [NO_OF_BURSTS-1:0]         wr_data_req_o,
  output logic [DATA_W-1:0]               dram_dq_o,
  output logic                            dram_dq_oe_o,
  output logic [DATA_W-1:0]               rd_data_o,
  output logic                            rd_valid_o,
  output logic [$clog2(NO_OF_BURSTS)-1:0] rd_id_o,
  output logic [NO_OF_BURSTS-1:0]         burst_done_o
);

  localparam int ID_W    = $clog2(NO_OF_BURSTS);
  localparam int BEAT_W  = $clog2(BURST_LEN);
  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int DLY_W   = $clog2(MAX_LAT + 1);
  localparam logic [DLY_W-1:0]  WR_DLY    = DLY_W'(WR_LAT - 1);
  localparam logic [DLY_W-1:0]  RD_DLY    = DLY_W'(RD_LAT - 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

  data_fsm_t         state_q, state_nxt;
  logic [DLY_W-1:0]  dly_q, dly_nxt;
  logic [BEAT_W-1:0] beat_q, beat_nxt;
  data_dir_t         dir_q, dir_nxt;
  logic [ID_W-1:0]   id_q, id_nxt;
  logic              wr_req;
  logic              done_set;

  logic [DATA_W-1:0]       dq_q;
  logic                    oe_q;
  logic [DATA_W-1:0]       rd_data_q;
  logic                    rd_valid_q;
  logic [ID_W-1:0]         rd_id_q;
  logic [NO_OF_BURSTS-1:0] done_q;

  // The final beat frees the FSM, so a new RD/WR can land in the done cycle.
  assign busy_o = !((state_q == IDLE) ||
                    (((state_q == XFER_WR) || (state_q == XFER_RD)) && (beat_q == BEAT_LAST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dly_q   <= '0;
      beat_q  <= '0;
      dir_q   <= DIR_RD;
      id_q    <= '0;
    end else begin
      state_q <= state_nxt;
      dly_q   <= dly_nxt;
      beat_q  <= beat_nxt;
      dir_q   <= dir_nxt;
      id_q    <= id_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    dly_nxt   = dly_q;
    beat_nxt  = beat_q;
    dir_nxt   = dir_q;
    id_nxt    = id_q;
    wr_req    = 1'b0;
    done_set  = 1'b0;
    case (state_q)
      IDLE: ;
      WAIT: begin
        if (dly_q == '0) begin
          wr_req    = (dir_q == DIR_WR);
          beat_nxt  = '0;
          state_nxt = (dir_q == DIR_WR) ? XFER_WR : XFER_RD;
        end else begin
          dly_nxt = dly_q - DLY_W'(1);
        end
      end
      XFER_WR: begin
        beat_nxt = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_LAST) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end else begin
          wr_req = 1'b1;
        end
      end
      XFER_RD: begin
        beat_nxt = beat_q + BEAT_W'(1);
        if (beat_q == BEAT_LAST) begin
          done_set  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (start_i) begin
      state_nxt = WAIT;
      dir_nxt   = dir_i;
      id_nxt    = id_i;
      dly_nxt   = (dir_i == DIR_WR) ? WR_DLY : RD_DLY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dq_q       <= '0;
      oe_q       <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_id_q    <= '0;
      done_q     <= '0;
    end else begin
      dq_q       <= wr_req ? wr_data_i : '0;
      oe_q       <= wr_req;
      rd_valid_q <= (state_q == XFER_RD);
      if (state_q == XFER_RD) begin
        rd_data_q <= dram_dq_i;
        rd_id_q   <= id_q;
      end
      done_q <= done_set ? (NO_OF_BURSTS'(1) << id_q) : '0;
    end
  end

  assign wr_data_req_o = wr_req ? (NO_OF_BURSTS'(1) << id_q) : '0;
  assign dram_dq_o     = dq_q;
  assign dram_dq_oe_o  = oe_q;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign rd_id_o       = rd_id_q;
  assign burst_done_o  = done_done_alias();

  function automatic logic [NO_OF_BURSTS-1:0] done_done_alias();
    return done_q;
  endfunction

endmodule

// File: rtl/dram_cmd_issuer.sv
// Picks the lowest-index slot command, registers it onto the DRAM command bus,
// flags collisions and hands RD/WR to the beat sequencer.
module dram_cmd_issuer
  import types_def::*;
#(
  parameter int NO_OF_BURSTS = 4,
  parameter int BURST_LEN    = 8,
  parameter int RD_LAT       = 6,
  parameter int WR_LAT       = 4,
  parameter int DATA_W       = 16
) (
  input  logic         clk,
  input  logic         rst,
  dram_cmd_issuer_if.slave bus
);

  localparam int ID_W = $clog2(NO_OF_BURSTS);

  command      sel_cmd;
  address_type sel_addr;
  logic [ID_W-1:0] sel_id;
  logic        found;
  logic        multi;
  logic        is_data;
  logic        seq_busy;
  logic        seq_start;
  data_dir_t   sel_dir;

  command      cmd_q;
  address_type addr_q;
  logic [1:0]  err_q;

  logic [NO_OF_BURSTS-1:0] wr_data_req;
  logic [DATA_W-1:0]       dq_out;
  logic                    dq_oe;
  logic [DATA_W-1:0]       rd_data;
  logic                    rd_valid;
  logic [ID_W-1:0]         rd_id;
  logic [NO_OF_BURSTS-1:0] burst_done;

  always_comb begin
    sel_cmd  = none;
    sel_addr = '0;
    sel_id   = '0;
    found    = 1'b0;
    multi    = 1'b0;
    for (int i = 0; i < NO_OF_BURSTS; i++) begin
      if (bus.burst_cmd_i[i] != none) begin
        if (found) begin
          multi = 1'b1;
        end else begin
          found    = 1'b1;
          sel_cmd  = bus.burst_cmd_i[i];
          sel_addr = bus.burst_addr_i[i];
          sel_id   = ID_W'(i);
        end
      end
    end
  end

  assign is_data   = is_data_cmd(sel_cmd);
  assign sel_dir   = (sel_cmd == write_cmd) ? DIR_WR : DIR_RD;
  assign seq_start = is_data && !seq_busy;

  // An overlapping RD/WR still goes on the bus; only its data phase is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q  <= none;
      addr_q <= '0;
      err_q  <= '0;
    end else begin
      cmd_q  <= sel_cmd;
      addr_q <= sel_addr;
      err_q  <= {is_data && seq_busy, multi};
    end
  end

  burst_beat_sequencer #(
    .NO_OF_BURSTS (NO_OF_BURSTS),
    .BURST_LEN    (BURST_LEN),
    .RD_LAT       (RD_LAT),
    .WR_LAT       (WR_LAT),
    .DATA_W       (DATA_W)
  ) u_seq (
    .clk           (clk),
    .rst           (rst),
    .start_i       (seq_start),
    .dir_i         (sel_dir),
    .id_i          (sel_id),
    .wr_data_i     (bus.wr_data_i),
    .dram_dq_i     (bus.dram_dq_i),
    .busy_o        (seq_busy),
    .wr_data_req_o (wr_data_req),
    .dram_dq_o     (dq_out),
    .dram_dq_oe_o  (dq_oe),
    .rd_data_o     (rd_data),
    .rd_valid_o    (rd_valid),
    .rd_id_o       (rd_id),
    .burst_done_o  (burst_done)
  );

  assign bus.dram_cmd_o    = cmd_q;
  assign bus.dram_addr_o   = addr_q;
  assign bus.err_o         = err_q;
  assign bus.wr_data_req_o = wr_data_req;
  assign bus.dram_dq_o     = dq_out;
  assign bus.dram_dq_oe_o  = dq_oe;
  assign bus.rd_data_o     = rd_data;
  assign bus.rd_valid_o    = rd_valid;
  assign bus.rd_id_o       = rd_id;
  assign bus.burst_done_o  = burst_done;

endmodule

// File: tb/tb_dram_cmd_issuer.sv
// Directed checks of the command issuer: reset, issue-only commands, write and
// read data phases, collision and overlap errors, back-to-back issue, mid-burst reset.
module tb_dram_cmd_issuer;
  import types_def::*;

  localparam int NB = 4;
  localparam int BL = 8;
  localparam int RL = 6;
  localparam int WL = 4;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  address_type a_act, a_wr, a_rd, a_pre, a_x;

  always #5 clk = ~clk;

  dram_cmd_issuer_if #(.NO_OF_BURSTS(NB), .DATA_W(DW)) bus ();

  dram_cmd_issuer #(
    .NO_OF_BURSTS (NB),
    .BURST_LEN    (BL),
    .RD_LAT       (RL),
    .WR_LAT       (WL),
    .DATA_W       (DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < NB; i++) begin
      bus.burst_cmd_i[i]  = none;
      bus.burst_addr_i[i] = '0;
    end
  endtask

  task automatic put(input int slot, input command c, input address_type a);
    bus.burst_cmd_i[slot]  = c;
    bus.burst_addr_i[slot] = a;
  endtask

  // One cycle of expected outputs; dq and read data are checked only when qualified.
  task automatic expect_cycle(input string tag, input int k, input command cmd,
                              input logic [3:0] req, input logic oe, input logic [15:0] dq,
                              input logic v, input logic [1:0] id, input logic [15:0] rd,
                              input logic [3:0] done, input logic [1:0] err);
    chk($sformatf("%s[%0d].cmd", tag, k), 32'(bus.dram_cmd_o), 32'(cmd));
    chk($sformatf("%s[%0d].req", tag, k), 32'(bus.wr_data_req_o), 32'(req));
    chk($sformatf("%s[%0d].oe", tag, k), 32'(bus.dram_dq_oe_o), 32'(oe));
    if (oe) chk($sformatf("%s[%0d].dq", tag, k), 32'(bus.dram_dq_o), 32'(dq));
    chk($sformatf("%s[%0d].valid", tag, k), 32'(bus.rd_valid_o), 32'(v));
    if (v) begin
      chk($sformatf("%s[%0d].rd_id", tag, k), 32'(bus.rd_id_o), 32'(id));
      chk($sformatf("%s[%0d].rd_data", tag, k), 32'(bus.rd_data_o), 32'(rd));
    end
    chk($sformatf("%s[%0d].done", tag, k), 32'(bus.burst_done_o), 32'(done));
    chk($sformatf("%s[%0d].err", tag, k), 32'(bus.err_o), 32'(err));
  endtask

  initial begin
    a_act = '{row: 16'h1234, column: 10'h02A, bank: 2'd1, bank_group: 2'd2};
    a_wr  = '{row: 16'h0F0F, column: 10'h100, bank: 2'd3, bank_group: 2'd0};
    a_rd  = '{row: 16'hBEEF, column: 10'h3F8, bank: 2'd2, bank_group: 2'd3};
    a_pre = '{row: 16'h0001, column: 10'h001, bank: 2'd0, bank_group: 2'd1};
    a_x   = '{row: 16'h7777, column: 10'h155, bank: 2'd1, bank_group: 2'd1};
    idle_inputs();
    bus.wr_data_i = 16'hDEAD;
    bus.dram_dq_i = 16'h5555;

    // reset state
    repeat (3) tick();
    expect_cycle("reset", 0, none, 4'b0000, 1'b0, 16'h0, 1'b0, 2'd0, 16'h0, 4'b0000, 2'b00);
    chk("reset.addr", 32'(bus.dram_addr_o), 32'h0);
    chk("reset.dq", 32'(bus.dram_dq_o), 32'h0);
    rst = 1'b0;
    tick();

    // activate on slot 2: one bus cycle, no data phase
    put(2, activate, a_act);
    for (int k = 0; k <= 8; k++) begin
      tick();
      if (k == 0) idle_inputs();
      if (k == 0) chk("act.addr", 32'(bus.dram_addr_o), 32'(a_act));
      expect_cycle("act", k, (k == 0) ? activate : none, 4'b0000, 1'b0, 16'h0,
                   1'b0, 2'd0, 16'h0, 4'b0000, 2'b00);
    end

    // write on slot 1, wr_data_i = beat index while requested
    put(1, write_cmd, a_wr);
    for (int k = 0; k <= 14; k++) begin
      tick();
      if (k == 0) idle_inputs();
      if (k == 0) chk("wr.addr", 32'(bus.dram_addr_o), 32'(a_wr));
      expect_cycle("wr", k, (k == 0) ? write_cmd : none,
                   (k >= 3 && k <= 10) ? 4'b0010 : 4'b0000,
                   (k >= 4 && k <= 11), 16'(k - 4),
                   1'b0, 2'd0, 16'h0, (k == 12) ? 4'b0010 : 4'b0000, 2'b00);
      bus.wr_data_i = (k >= 3 && k <= 10) ? 16'(k - 3) : 16'hDEAD;
    end

    // read on slot 3, dram_dq_i = A000+beat while sampled
    put(3, read_cmd, a_rd);
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k == 0) idle_inputs();
      if (k == 0) chk("rd.addr", 32'(bus.dram_addr_o), 32'(a_rd));
      expect_cycle("rd", k, (k == 0) ? read_cmd : none, 4'b0000, 1'b0, 16'h0,
                   (k >= 7 && k <= 14), 2'd3, 16'hA000 + 16'(k - 7),
                   (k == 14) ? 4'b1000 : 4'b0000, 2'b00);
      bus.dram_dq_i = (k >= 6 && k <= 13) ? 16'hA000 + 16'(k - 6) : 16'h5555;
    end

    // precharge on slot 0 collides with read on slot 2: precharge wins, read dropped
    put(0, precharge, a_pre);
    put(2, read_cmd, a_rd);
    for (int k = 0; k <= 16; k++) begin
      tick();
      if (k == 0) idle_inputs();
      if (k == 0) chk("coll.addr", 32'(bus.dram_addr_o), 32'(a_pre));
      expect_cycle("coll", k, (k == 0) ? precharge : none, 4'b0000, 1'b0, 16'h0,
                   1'b0, 2'd0, 16'h0, 4'b0000, (k == 0) ? 2'b01 : 2'b00);
    end

    // second read at C+3 overlaps the first: issued, flagged, no data phase of its own
    put(0, read_cmd, a_rd);
    for (int k = 0; k <= 20; k++) begin
      tick();
      if (k == 0 || k == 3) idle_inputs();
      expect_cycle("ovl", k, (k == 0 || k == 3) ? read_cmd : none, 4'b0000, 1'b0, 16'h0,
                   (k >= 7 && k <= 14), 2'd0, 16'hB000 + 16'(k - 7),
                   (k == 14) ? 4'b0001 : 4'b0000, (k == 3) ? 2'b10 : 2'b00);
      if (k == 2) put(1, read_cmd, a_x);
      bus.dram_dq_i = (k >= 6 && k <= 13) ? 16'hB000 + 16'(k - 6) : 16'h5555;
    end

    // write on slot 2, then read on slot 3 landing in the write's done cycle
    put(2, write_cmd, a_wr);
    for (int k = 0; k <= 28; k++) begin
      tick();
      if (k == 0 || k == 12) idle_inputs();
      expect_cycle("b2b", k, (k == 0) ? write_cmd : (k == 12) ? read_cmd : none,
                   (k >= 3 && k <= 10) ? 4'b0100 : 4'b0000,
                   (k >= 4 && k <= 11), 16'h40 + 16'(k - 4),
                   (k >= 19 && k <= 26), 2'd3, 16'hC000 + 16'(k - 19),
                   (k == 12) ? 4'b0100 : (k == 26) ? 4'b1000 : 4'b0000, 2'b00);
      if (k == 11) put(3, read_cmd, a_rd);
      bus.wr_data_i = (k >= 3 && k <= 10) ? 16'h40 + 16'(k - 3) : 16'hDEAD;
      bus.dram_dq_i = (k >= 18 && k <= 25) ? 16'hC000 + 16'(k - 18) : 16'h5555;
    end

    // reset while beat 3 of a write is on DQ
    put(1, write_cmd, a_wr);
    for (int k = 0; k <= 7; k++) begin
      tick();
      if (k == 0) idle_inputs();
      bus.wr_data_i = (k >= 3 && k <= 10) ? 16'(k - 3) : 16'hDEAD;
    end
    chk("mrst.pre_oe", 32'(bus.dram_dq_oe_o), 32'h1);
    chk("mrst.pre_dq", 32'(bus.dram_dq_o), 32'h3);
    #2 rst = 1'b1;
    #1;
    chk("mrst.oe", 32'(bus.dram_dq_oe_o), 32'h0);
    chk("mrst.dq", 32'(bus.dram_dq_o), 32'h0);
    chk("mrst.req", 32'(bus.wr_data_req_o), 32'h0);
    chk("mrst.cmd", 32'(bus.dram_cmd_o), 32'(none));
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      tick();
      expect_cycle("post_rst", k, none, 4'b0000, 1'b0, 16'h0, 1'b0, 2'd0, 16'h0,
                   4'b0000, 2'b00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
